// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe; widths follow the exponent/fraction parameters.
interface fp_mul_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int XLEN = 1 + EXP_W + MAN_W;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [3:0]      flags;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754 multiplier: classify, multiply/exponent add, normalise/round/pack.
// One global enable from the output stage stalls every stage together so results never reorder.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic          clk,
  input logic          rst_n,
  fp_mul_pipe_if.slave bus
);
  localparam int XLEN   = 1 + EXP_W + MAN_W;
  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int E_W    = EXP_W + 2;
  localparam logic signed [E_W-1:0] BIAS   = E_W'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [E_W-1:0] E_MAX  = E_W'((1 << EXP_W) - 1);
  localparam logic signed [E_W-1:0] E_ZERO = '0;
  localparam logic [EXP_W-1:0]      EXP_ONES = '1;

  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

  logic adv;
  logic v1_reg, v2_reg, v3_reg;

  assign adv          = !v3_reg || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = v3_reg;

  logic [1:0][XLEN-1:0]  opnd;
  logic [1:0][EXP_W-1:0] exp_f;
  logic [1:0][MAN_W-1:0] frac_f;
  logic [1:0]            sgn, is_zero, is_inf, is_nan, is_snan;

  assign opnd = {bus.b, bus.a};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cls
      assign sgn[gi]     = opnd[gi][XLEN-1];
      assign exp_f[gi]   = opnd[gi][XLEN-2 -: EXP_W];
      assign frac_f[gi]  = opnd[gi][MAN_W-1:0];
      // Subnormals fall into the zero class (flush-to-zero on input).
      assign is_zero[gi] = (exp_f[gi] == '0);
      assign is_inf[gi]  = (exp_f[gi] == EXP_ONES) && (frac_f[gi] == '0);
      assign is_nan[gi]  = (exp_f[gi] == EXP_ONES) && (frac_f[gi] != '0);
      assign is_snan[gi] = is_nan[gi] && !frac_f[gi][MAN_W-1];
    end
  endgenerate

  logic     inf_zero;
  special_t sp1_next;

  assign inf_zero = (is_inf[0] && is_zero[1]) || (is_inf[1] && is_zero[0]);

  always_comb begin
    sp1_next = SP_NONE;
    if ((|is_nan) || inf_zero) begin
      sp1_next = SP_NAN;
    end else if (|is_inf) begin
      sp1_next = SP_INF;
    end else if (|is_zero) begin
      sp1_next = SP_ZERO;
    end
  end

  special_t              sp1_reg, sp2_reg;
  logic                  sign1_reg, sign2_reg, inv1_reg, inv2_reg;
  logic [EXP_W-1:0]      ea1_reg, eb1_reg;
  logic [SIG_W-1:0]      ma1_reg, mb1_reg;
  logic [PROD_W-1:0]     prod2_reg;
  logic signed [E_W-1:0] e2_reg;
  logic [XLEN-1:0]       result_reg, result_next;
  logic [3:0]            flags_reg, flags_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_reg     <= 1'b0;
      v2_reg     <= 1'b0;
      v3_reg     <= 1'b0;
      result_reg <= '0;
      flags_reg  <= '0;
    end else if (adv) begin
      v1_reg <= bus.in_valid;
      v2_reg <= v1_reg;
      v3_reg <= v2_reg;
      if (v2_reg) begin
        result_reg <= result_next;
        flags_reg  <= flags_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      sign1_reg <= sgn[0] ^ sgn[1];
      sp1_reg   <= sp1_next;
      inv1_reg  <= inf_zero || (|is_snan);
      ea1_reg   <= exp_f[0];
      eb1_reg   <= exp_f[1];
      ma1_reg   <= {1'b1, frac_f[0]};
      mb1_reg   <= {1'b1, frac_f[1]};

      sign2_reg <= sign1_reg;
      sp2_reg   <= sp1_reg;
      inv2_reg  <= inv1_reg;
      prod2_reg <= PROD_W'(ma1_reg) * PROD_W'(mb1_reg);
      e2_reg    <= $signed({2'b00, ea1_reg}) + $signed({2'b00, eb1_reg}) - BIAS;
    end
  end

  assign bus.result = result_reg;
  assign bus.flags  = flags_reg;

  logic [PROD_W-1:0]     prod_n;
  logic signed [E_W-1:0] e_n, e_r;
  logic [SIG_W-1:0]      sig;
  logic [SIG_W:0]        sig_r;
  logic [MAN_W-1:0]      frac_r;
  logic                  guard, rnd, sticky, round_up;

  always_comb begin
    // Left-align the leading one instead of shifting right; the exponent bump is the same.
    prod_n   = prod2_reg[PROD_W-1] ? prod2_reg : {prod2_reg[PROD_W-2:0], 1'b0};
    e_n      = e2_reg + $signed({{(E_W-1){1'b0}}, prod2_reg[PROD_W-1]});
    sig      = prod_n[PROD_W-1 -: SIG_W];
    guard    = prod_n[MAN_W];
    rnd      = prod_n[MAN_W-1];
    sticky   = |prod_n[MAN_W-2:0];
    round_up = guard && (rnd || sticky || sig[0]);
    sig_r    = {1'b0, sig} + {{SIG_W{1'b0}}, round_up};
    frac_r   = sig_r[SIG_W] ? sig_r[MAN_W:1] : sig_r[MAN_W-1:0];
    e_r      = e_n + $signed({{(E_W-1){1'b0}}, sig_r[SIG_W]});

    result_next = '0;
    flags_next  = '0;
    case (sp2_reg)
      SP_NAN: begin
        result_next = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
        flags_next  = {inv2_reg, 3'b000};
      end
      SP_INF:  result_next = {sign2_reg, EXP_ONES, {MAN_W{1'b0}}};
      SP_ZERO: result_next = {sign2_reg, {(EXP_W+MAN_W){1'b0}}};
      default: begin
        if (e_r >= E_MAX) begin
          result_next = {sign2_reg, EXP_ONES, {MAN_W{1'b0}}};
          flags_next  = 4'b0101;
        end else if (e_r <= E_ZERO) begin
          result_next = {sign2_reg, {(EXP_W+MAN_W){1'b0}}};
          flags_next  = 4'b0011;
        end else begin
          result_next = {sign2_reg, e_r[EXP_W-1:0], frac_r};
          flags_next  = {3'b000, guard | rnd | sticky};
        end
      end
    endcase
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Randomised and directed bench for fp_mul_pipe at FP32 and FP16, checked against an
// arithmetic reference model through an in-order scoreboard.
module tb_fp_mul_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_mul_pipe_if #(.EXP_W(8), .MAN_W(23)) bus32 ();
  fp_mul_pipe_if #(.EXP_W(5), .MAN_W(10)) bus16 ();

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  logic        drv_valid [2];
  logic [63:0] drv_a [2];
  logic [63:0] drv_b [2];
  logic        out_rdy [2];
  logic        mon_in_ready [2];
  logic        mon_out_valid [2];
  logic [63:0] mon_res [2];
  logic [3:0]  mon_flags [2];

  assign bus32.in_valid  = drv_valid[0];
  assign bus32.a         = drv_a[0][31:0];
  assign bus32.b         = drv_b[0][31:0];
  assign bus32.out_ready = out_rdy[0];
  assign bus16.in_valid  = drv_valid[1];
  assign bus16.a         = drv_a[1][15:0];
  assign bus16.b         = drv_b[1][15:0];
  assign bus16.out_ready = out_rdy[1];

  assign mon_in_ready[0]  = bus32.in_ready;
  assign mon_out_valid[0] = bus32.out_valid;
  assign mon_res[0]       = 64'(bus32.result);
  assign mon_flags[0]     = bus32.flags;
  assign mon_in_ready[1]  = bus16.in_ready;
  assign mon_out_valid[1] = bus16.out_valid;
  assign mon_res[1]       = 64'(bus16.result);
  assign mon_flags[1]     = bus16.flags;

  typedef struct {
    logic [63:0] r;
    logic [3:0]  f;
    int          acc;
    bit          lat;
  } exp_t;

  typedef struct {
    int          k;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    logic [3:0]  f;
  } vec_t;

  exp_t        sb [2][$];
  logic [63:0] src_a [2][$];
  logic [63:0] src_b [2][$];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          rst_prev = 1'b0;
  bit          lat_req = 1'b0;
  bit          stall_prev [2];
  bit          acc_flag [2];
  logic [63:0] held_res [2];
  logic [3:0]  held_flags [2];
  int          ret_cnt [2];
  int          base_cnt [2];

  vec_t vt [18] = '{
    '{0, 64'h3FC00000, 64'h40000000, 64'h40400000, 4'b0000},
    '{0, 64'h3F800001, 64'h3F800001, 64'h3F800002, 4'b0001},
    '{0, 64'h3F800001, 64'h3FC00000, 64'h3FC00002, 4'b0001},
    '{0, 64'h7F800000, 64'h00000000, 64'h7FC00000, 4'b1000},
    '{0, 64'hFF800000, 64'h40000000, 64'hFF800000, 4'b0000},
    '{0, 64'h00000001, 64'h40000000, 64'h00000000, 4'b0000},
    '{0, 64'h7F000000, 64'h7F000000, 64'h7F800000, 4'b0101},
    '{0, 64'h00800000, 64'h3F000000, 64'h00000000, 4'b0011},
    '{0, 64'h7FA00000, 64'h3F800000, 64'h7FC00000, 4'b1000},
    '{0, 64'hFFC00001, 64'h00000000, 64'h7FC00000, 4'b0000},
    '{1, 64'h3E00, 64'h4000, 64'h4200, 4'b0000},
    '{1, 64'h3C01, 64'h3C01, 64'h3C02, 4'b0001},
    '{1, 64'h3C01, 64'h3E00, 64'h3E02, 4'b0001},
    '{1, 64'h7C00, 64'h0000, 64'h7E00, 4'b1000},
    '{1, 64'hFC00, 64'h4000, 64'hFC00, 4'b0000},
    '{1, 64'h0001, 64'h4000, 64'h0000, 4'b0000},
    '{1, 64'h7800, 64'h7800, 64'h7C00, 4'b0101},
    '{1, 64'h0400, 64'h3800, 64'h0000, 4'b0011}
  };

  function automatic int ew_of(input int k);
    return (k == 0) ? 8 : 5;
  endfunction

  function automatic int mw_of(input int k);
    return (k == 0) ? 23 : 10;
  endfunction

  // Value-level model: exact integer product, round-half-even on the discarded remainder.
  function automatic void ref_mul(input int ew, input int mw, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] r,
                                  output logic [3:0] f);
    longint one = 1;
    longint emax = (one << ew) - 1;
    longint bias = (one << (ew - 1)) - 1;
    longint fmask = (one << mw) - 1;
    longint ea = longint'(a >> mw) & emax;
    longint eb = longint'(b >> mw) & emax;
    longint fa = longint'(a) & fmask;
    longint fb = longint'(b) & fmask;
    longint p, q, rem, half, e;
    int     sh;
    bit     sign, na, nb, sna, snb, ia, ib, za, zb;
    sign = a[ew+mw] ^ b[ew+mw];
    na  = (ea == emax) && (fa != 0);
    nb  = (eb == emax) && (fb != 0);
    sna = na && (((fa >> (mw - 1)) & 1) == 0);
    snb = nb && (((fb >> (mw - 1)) & 1) == 0);
    ia  = (ea == emax) && (fa == 0);
    ib  = (eb == emax) && (fb == 0);
    za  = (ea == 0);
    zb  = (eb == 0);
    r = '0;
    f = 4'b0000;
    if (na || nb || (ia && zb) || (ib && za)) begin
      r = 64'((emax << mw) | (one << (mw - 1)));
      f = {(ia && zb) || (ib && za) || sna || snb, 3'b000};
    end else if (ia || ib) begin
      r = (64'(sign) << (ew + mw)) | 64'(emax << mw);
    end else if (za || zb) begin
      r = 64'(sign) << (ew + mw);
    end else begin
      p = (fa | (one << mw)) * (fb | (one << mw));
      e = ea + eb - bias;
      sh = mw;
      if ((p >> (2 * mw + 1)) != 0) begin
        sh = mw + 1;
        e++;
      end
      q = p >> sh;
      rem = p & ((one << sh) - 1);
      half = one << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if ((q >> (mw + 1)) != 0) begin
        q = q >> 1;
        e++;
      end
      if (e >= emax) begin
        r = (64'(sign) << (ew + mw)) | 64'(emax << mw);
        f = 4'b0101;
      end else if (e <= 0) begin
        r = 64'(sign) << (ew + mw);
        f = 4'b0011;
      end else begin
        r = (64'(sign) << (ew + mw)) | 64'(e << mw) | 64'(q & fmask);
        f = {3'b000, rem != 0};
      end
    end
  endfunction

  function automatic logic [63:0] rand_op(input int k);
    int     ew = ew_of(k);
    int     mw = mw_of(k);
    longint one = 1;
    longint emax = (one << ew) - 1;
    longint bias = (one << (ew - 1)) - 1;
    longint fr = longint'({$urandom(), $urandom()}) & ((one << mw) - 1);
    longint e;
    bit     s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 11))
      0:       e = 0;
      1:       begin e = emax; fr = 0; end
      2:       e = emax;
      3, 4, 5: e = longint'($urandom_range(1, int'(emax - 1)));
      default: e = bias - 3 + longint'($urandom_range(0, 6));
    endcase
    if ($urandom_range(0, 3) == 0) fr = fr & 15;
    return (64'(s) << (ew + mw)) | 64'(e << mw) | 64'(fr);
  endfunction

  task automatic chk(input string name, input int k, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s inst=%0d got=%h want=%h", name, k, got, want);
    end
  endtask

  task automatic monitor();
    exp_t e;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        if (rst_prev) chk("rst_out_valid", k, 64'(mon_out_valid[k]), 64'd0);
        sb[k].delete();
        stall_prev[k] = 1'b0;
        acc_flag[k] = 1'b0;
      end else begin
        if (rst_prev) begin
          chk("rst_out_valid", k, 64'(mon_out_valid[k]), 64'd0);
          chk("rst_result", k, mon_res[k], 64'd0);
          chk("rst_flags", k, 64'(mon_flags[k]), 64'd0);
        end
        chk("in_ready", k, 64'(mon_in_ready[k]), 64'(!mon_out_valid[k] || out_rdy[k]));
        if (stall_prev[k]) begin
          chk("hold_valid", k, 64'(mon_out_valid[k]), 64'd1);
          chk("hold_result", k, mon_res[k], held_res[k]);
          chk("hold_flags", k, 64'(mon_flags[k]), 64'(held_flags[k]));
        end
        if (mon_out_valid[k] && out_rdy[k]) begin
          if (sb[k].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result inst=%0d got=%h want=none", k, mon_res[k]);
          end else begin
            e = sb[k].pop_front();
            chk("result", k, mon_res[k], e.r);
            chk("flags", k, 64'(mon_flags[k]), 64'(e.f));
            if (e.lat) chk("latency", k, 64'(cyc - e.acc), 64'd3);
            ret_cnt[k]++;
          end
        end
        stall_prev[k] = mon_out_valid[k] && !out_rdy[k];
        held_res[k] = mon_res[k];
        held_flags[k] = mon_flags[k];
        acc_flag[k] = drv_valid[k] && mon_in_ready[k];
        if (acc_flag[k]) begin
          ref_mul(ew_of(k), mw_of(k), drv_a[k], drv_b[k], e.r, e.f);
          e.acc = cyc;
          e.lat = lat_req;
          sb[k].push_back(e);
        end
      end
    end
    rst_prev = !rst_n;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  // Hold each operand until it is accepted, then take the next queued or random one.
  task automatic step(input bit rnd);
    for (int k = 0; k < 2; k++) begin
      if (!drv_valid[k] || acc_flag[k]) begin
        if (src_a[k].size() > 0) begin
          drv_valid[k] = 1'b1;
          drv_a[k] = src_a[k].pop_front();
          drv_b[k] = src_b[k].pop_front();
        end else if (rnd && $urandom_range(0, 9) < 7) begin
          drv_valid[k] = 1'b1;
          drv_a[k] = rand_op(k);
          drv_b[k] = rand_op(k);
        end else begin
          drv_valid[k] = 1'b0;
        end
      end
    end
    tick();
  endtask

  initial begin
    logic [63:0] mr;
    logic [3:0]  mf;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drv_valid[k] = 1'b0;
      drv_a[k] = '0;
      drv_b[k] = '0;
      out_rdy[k] = 1'b1;
      stall_prev[k] = 1'b0;
      acc_flag[k] = 1'b0;
      ret_cnt[k] = 0;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 18; i++) begin
      ref_mul(ew_of(vt[i].k), mw_of(vt[i].k), vt[i].a, vt[i].b, mr, mf);
      chk("model_result", vt[i].k, mr, vt[i].r);
      chk("model_flags", vt[i].k, 64'(mf), 64'(vt[i].f));
      src_a[vt[i].k].push_back(vt[i].a);
      src_b[vt[i].k].push_back(vt[i].b);
    end
    lat_req = 1'b1;
    repeat (30) step(1'b0);
    lat_req = 1'b0;
    for (int k = 0; k < 2; k++) chk("directed_drain", k, 64'(sb[k].size()), 64'd0);

    for (int k = 0; k < 2; k++) begin
      base_cnt[k] = ret_cnt[k];
      repeat (6) begin
        src_a[k].push_back(rand_op(k));
        src_b[k].push_back(rand_op(k));
      end
    end
    for (int c = 1; c <= 24; c++) begin
      for (int k = 0; k < 2; k++) out_rdy[k] = !(c >= 4 && c <= 9);
      step(1'b0);
    end
    for (int k = 0; k < 2; k++) begin
      chk("bp_delivered", k, 64'(ret_cnt[k] - base_cnt[k]), 64'd6);
      chk("bp_drain", k, 64'(sb[k].size()), 64'd0);
    end

    for (int k = 0; k < 2; k++) begin
      base_cnt[k] = ret_cnt[k];
      out_rdy[k] = 1'b1;
      repeat (3) begin
        src_a[k].push_back(rand_op(k));
        src_b[k].push_back(rand_op(k));
      end
    end
    repeat (3) step(1'b0);
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) drv_valid[k] = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (12) step(1'b0);
    for (int k = 0; k < 2; k++) chk("rst_no_stale", k, 64'(ret_cnt[k] - base_cnt[k]), 64'd0);

    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) out_rdy[k] = ($urandom_range(0, 9) < 7);
      step(1'b1);
    end
    for (int k = 0; k < 2; k++) out_rdy[k] = 1'b1;
    repeat (12) step(1'b0);
    for (int k = 0; k < 2; k++) chk("random_drain", k, 64'(sb[k].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fp_mul_pipe.md
# fp_mul_pipe

Pipelined, parametrised IEEE-754 floating-point multiplier with a valid/ready handshake on both sides. It is the successor to the single-cycle FP32 multiplier and generalises it in three ways: configurable exponent and mantissa widths, round-to-nearest-even, and full special-value handling with exception flags. It sits in the datapath between the operand-issue logic and the result writeback, and it must absorb backpressure from writeback without losing or reordering results.

## Interface
- EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1
- MAN_W, 23, stored fraction width; XLEN = 1+EXP_W+MAN_W (derived, not overridable)
- clk  input  1  clock; all logic is rising-edge
- rst_n  input  1  synchronous, active-low reset; sampled on rising clk
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands this cycle
- a, b  input  XLEN each  operands {sign, exp, frac}
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result this cycle
- result  output  XLEN  product
- flags  output  4  {invalid, overflow, underflow, inexact}, aligned with result

## Operation
- Three stages: S1 unpack/classify; S2 significand multiply and exponent add; S3 normalise, round, pack. Each stage carries its own valid bit.
- Pipeline control is a global enable: adv = !v3 || out_ready. All stage registers load only when adv=1. in_ready = adv. An operand is accepted when in_valid && in_ready.
- Classification is per operand: zero (exp=0; subnormals are flushed to zero, no flag), inf (exp all ones, frac=0), NaN (exp all ones, frac≠0), or normal.
- sign = a.sign ^ b.sign in all cases except NaN results.
- Special results, in priority order:
  - any NaN operand, or inf×zero → canonical qNaN (sign 0, exp all ones, frac MSB 1, rest 0); invalid=1 only for inf×zero or a signalling NaN input (frac MSB 0).
  - inf×(inf or normal) → signed inf, no flags.
  - zero×(zero or normal) → signed zero, no flags.
- Normal path:
  - Significands are {1,frac}, each MAN_W+1 bits; product P is 2·MAN_W+2 bits.
  - Exponent is computed signed in EXP_W+2 bits: e = ea + eb − bias.
  - If P MSB = 1: shift right by 1 and e+1.
  - Take MAN_W fraction bits plus guard, round and sticky (OR of all remaining bits). Round to nearest, ties to even.
  - If rounding carries out of the significand, renormalise and e+1.
- Overflow: e ≥ 2^EXP_W−1 → signed inf; overflow=1, inexact=1.
- Underflow: e ≤ 0 → signed zero (flush-to-zero); underflow=1, inexact=1.
- inexact=1 whenever guard|round|sticky ≠ 0 on the normal path.

## Timing
- Latency is 3 cycles from acceptance to out_valid when unstalled. Throughput is 1 per cycle.
- With out_valid=1 and out_ready=0, result and flags hold stable, and in_ready=0 in the same cycle (combinational from out_ready).
- Bubbles (stage valid=0) do not stall acceptance, because adv depends only on v3.
- Results leave in acceptance order; the block never drops or duplicates a result.
- Reset: v1, v2, v3 = 0; out_valid=0, result=0, flags=0. in_ready=1 in the first cycle after reset is released.
- Reset asserted mid-operation discards all in-flight operations. No result appears for them after rst_n returns high.
- Simultaneous out_ready=1 with a full pipeline and in_valid=1: one result retires and one operand is accepted in the same cycle.

## Test plan
- FP32 defaults: 0x3FC00000 × 0x40000000 → 0x40400000, flags 0000, out_valid exactly 3 cycles after acceptance.
- Rounding: 0x3F800001 × 0x3F800001 → 0x3F800002, inexact=1. Tie case: 0x3F800001 × 0x3FC00000 → 0x3FC00002 (ties-to-even), inexact=1.
- Specials:
  - 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1.
  - 0xFF800000 × 0x40000000 → 0xFF800000, flags 0.
  - 0x00000001 × 0x40000000 → 0x00000000, flags 0.
- Range limits:
  - 0x7F000000 × 0x7F000000 → 0x7F800000, overflow=1, inexact=1.
  - 0x00800000 × 0x3F000000 → 0x00000000, underflow=1, inexact=1.
- Backpressure: issue 6 back-to-back operations with out_ready=0 for cycles 4–9. Require in_ready=0 while stalled, result held stable, all 6 results delivered in order, none lost.
- Reset and parametrisation: assert rst_n=0 with 3 operations in flight → out_valid=0 next cycle, no stale results afterwards. Rerun the first four scenarios at EXP_W=5, MAN_W=10 (FP16), e.g. 0x3E00 × 0x4000 → 0x4200.
